// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding and 16x oversampling constants.
package uart_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_rx_state_t;

   localparam int         OS_RATE = 16;
   localparam logic [3:0] OS_S0   = 4'd6;
   localparam logic [3:0] OS_S1   = 4'd7;
   localparam logic [3:0] OS_S2   = 4'd8;
endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: counts 0..i_div, ticking on the terminal count.
module uart_baud_tick #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_nrst,
   input  logic                 i_clr,
   input  logic [DIV_WIDTH-1:0] i_div,
   output logic                 o_tick
);
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d, cnt_eff;

   // A clear makes the current cycle count 0, so with i_div = 0 it ticks at once.
   always_comb begin
      cnt_eff = i_clr ? '0 : cnt_q;
      o_tick  = (cnt_eff == i_div);
      cnt_d   = o_tick ? '0 : cnt_eff + DIV_WIDTH'(1);
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampled start qualification, majority-voted
// bits, LSB-first assembly, parity and stop checks, one-cycle valid pulse.
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_nrst,
   input  logic                 i_rx,
   input  logic [DIV_WIDTH-1:0] i_baud_div,
   input  logic                 i_parity_en,
   input  logic                 i_parity_odd,
   input  logic                 i_two_stop,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_busy
);
   uart_rx_state_t       state_q, state_d;
   logic                 armed_q, armed_d;
   logic [DIV_WIDTH-1:0] div_q, div_d, div_eff;
   logic                 par_en_q, par_en_d, par_odd_q, par_odd_d, two_stop_q, two_stop_d;
   logic [3:0]           os_q, os_d, os_eff, bit_q, bit_d;
   logic [1:0]           smp_q, smp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic                 perr_q, perr_d, ferr_q, ferr_d;
   logic                 valid_q, valid_d, operr_q, operr_d, oferr_q, oferr_d;
   logic                 start_det, tick, decide, wrap, maj;

   assign start_det = (state_q == ST_IDLE) && armed_q && !i_rx;
   // The detect cycle already runs on the new divider, before it is latched.
   assign div_eff   = start_det ? i_baud_div : div_q;
   assign os_eff    = start_det ? 4'd0 : os_q;

   uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
      .i_clk  (i_clk),
      .i_nrst (i_nrst),
      .i_clr  (start_det),
      .i_div  (div_eff),
      .o_tick (tick)
   );

   assign decide = tick && (os_eff == OS_S2) && (state_q != ST_IDLE);
   assign wrap   = tick && (os_eff == 4'(OS_RATE - 1)) && (state_q != ST_IDLE);
   assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & i_rx) | (smp_q[1] & i_rx);

   always_comb begin
      state_d    = state_q;
      armed_d    = armed_q;
      div_d      = div_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      two_stop_d = two_stop_q;
      os_d       = tick ? os_eff + 4'd1 : os_eff;
      bit_d      = bit_q;
      smp_d      = smp_q;
      shift_d    = shift_q;
      data_d     = data_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      valid_d    = 1'b0;
      operr_d    = 1'b0;
      oferr_d    = 1'b0;

      if (tick && os_eff == OS_S0) smp_d[0] = i_rx;
      if (tick && os_eff == OS_S1) smp_d[1] = i_rx;
      if (state_q == ST_IDLE && i_rx) armed_d = 1'b1;

      unique case (state_q)
         ST_IDLE: if (start_det) begin
            state_d    = ST_START;
            div_d      = i_baud_div;
            par_en_d   = i_parity_en;
            par_odd_d  = i_parity_odd;
            two_stop_d = i_two_stop;
            bit_d      = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
         end
         ST_START: begin
            if (decide && maj) state_d = ST_IDLE;
            else if (wrap)     state_d = ST_DATA;
         end
         ST_DATA: begin
            if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
            if (wrap) begin
               if (bit_q == 4'(DATA_BITS - 1)) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (decide) perr_d = (^shift_q) ^ maj ^ par_odd_q;
            if (wrap) state_d = ST_STOP;
         end
         ST_STOP: begin
            // Linger for the valid cycle so busy covers it; next cycle is IDLE.
            if (valid_q) begin
               state_d = ST_IDLE;
            end else if (decide) begin
               if (bit_q == {3'b000, two_stop_q}) begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
                  operr_d = par_en_q & perr_q;
                  oferr_d = ferr_q | ~maj;
               end else begin
                  ferr_d = ferr_q | ~maj;
               end
            end else if (wrap) begin
               bit_d = bit_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q    <= ST_IDLE;
         armed_q    <= 1'b0;
         div_q      <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         two_stop_q <= 1'b0;
         os_q       <= '0;
         bit_q      <= '0;
         smp_q      <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         valid_q    <= 1'b0;
         operr_q    <= 1'b0;
         oferr_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         armed_q    <= armed_d;
         div_q      <= div_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         two_stop_q <= two_stop_d;
         os_q       <= os_d;
         bit_q      <= bit_d;
         smp_q      <= smp_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         valid_q    <= valid_d;
         operr_q    <= operr_d;
         oferr_q    <= oferr_d;
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_parity_err = operr_q;
   assign o_frame_err  = oferr_q;
   assign o_busy       = (state_q != ST_IDLE);
endmodule
